// File: rtl/dco_pkg.sv
// Shared constants and the clamped half-period calculation for the DCO model.
package dco_pkg;

  localparam int DCO_CELLS = 132;
  localparam int DCO_CNT_W = 16;
  localparam int DCO_N_W   = 8;

  localparam int DCO_HALF_MAX_DEF  = 200;
  localparam int DCO_HALF_STEP_DEF = 1;
  localparam int DCO_HALF_MIN_DEF  = 2;

  // Clamp to hmin before subtracting so the result never wraps.
  function automatic logic [DCO_CNT_W-1:0] dco_half_calc(
    input logic [DCO_N_W-1:0] n,
    input int                 hmax,
    input int                 hstep,
    input int                 hmin
  );
    int prod;
    prod = int'(n) * hstep;
    if (prod + hmin > hmax) begin
      return DCO_CNT_W'(hmin);
    end
    return DCO_CNT_W'(hmax - prod);
  endfunction

endpackage

// File: rtl/dco_model_if.sv
// Connection between the PLL controller (master) and the DCO (slave).
interface dco_model_if;
  // No handshake: en is a level sampled every clk edge, and dco_out and
  // thermo_err are registered levels that are valid on every cycle.
  logic [dco_pkg::DCO_CELLS-1:0] en;
  logic                          dco_out;
  logic                          thermo_err;

  modport master (output en, input dco_out, input thermo_err);
  modport slave  (input en, output dco_out, output thermo_err);
endinterface

// File: rtl/dco_popcount.sv
// Combinational population count of the 132 enable bits as a binary adder tree.
module dco_popcount
  import dco_pkg::*;
(
  input  logic [DCO_CELLS-1:0] bits_i,
  output logic [DCO_N_W-1:0]   count_o
);

  // 2^8 leaves cover all 132 cells; unused leaves are tied to zero.
  localparam int LEVELS = 8;

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int W = 256 >> l;
    logic [DCO_N_W-1:0] s [W];
    for (genvar i = 0; i < W; i++) begin : g_node
      if (l == 0) begin : g_leaf
        if (i < DCO_CELLS) begin : g_bit
          assign s[i] = DCO_N_W'(bits_i[i]);
        end else begin : g_pad
          assign s[i] = '0;
        end
      end else begin : g_sum
        assign s[i] = g_lvl[l-1].s[2*i] + g_lvl[l-1].s[2*i+1];
      end
    end
  end

  assign count_o = g_lvl[LEVELS].s[0];

endmodule

// File: rtl/dco_model.sv
// Digitally controlled oscillator: half-period in clk cycles shrinks with popcount(en).
// Optional thermometer-code checker enabled by defining DCO_THERMO_CHECK_EN.
module dco_model
  import dco_pkg::*;
#(
  parameter int HALF_MAX  = DCO_HALF_MAX_DEF,
  parameter int HALF_STEP = DCO_HALF_STEP_DEF,
  parameter int HALF_MIN  = DCO_HALF_MIN_DEF
) (
  input  logic        clk,
  input  logic        reset,
  dco_model_if.slave  dco
);

  logic [DCO_N_W-1:0]   n_w;
  logic [DCO_CNT_W-1:0] half_new_w;
  logic                 tc_w;

  logic [DCO_CNT_W-1:0] cnt_q, cnt_d;
  logic [DCO_CNT_W-1:0] half_q, half_d;
  logic                 out_q, out_d;

  dco_popcount u_popcount (
    .bits_i  (dco.en),
    .count_o (n_w)
  );

  assign half_new_w = dco_half_calc(n_w, HALF_MAX, HALF_STEP, HALF_MIN);
  assign tc_w       = (cnt_q == half_q - DCO_CNT_W'(1));

  // A new half-period is only loaded at a toggle, so mid-half en changes never cut a pulse short.
  always_comb begin
    cnt_d  = cnt_q + DCO_CNT_W'(1);
    half_d = half_q;
    out_d  = out_q;
    if (tc_w) begin
      cnt_d  = '0;
      half_d = half_new_w;
      out_d  = ~out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      half_q <= DCO_CNT_W'(HALF_MAX);
      out_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
      out_q  <= out_d;
    end
  end

  assign dco.dco_out = out_q;

`ifdef DCO_THERMO_CHECK_EN
  logic err_q, err_d;

  // A set bit whose lower neighbour is clear marks a gap in the thermometer code.
  assign err_d = |(dco.en[DCO_CELLS-1:1] & ~dco.en[DCO_CELLS-2:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign dco.thermo_err = err_q;
`else
  assign dco.thermo_err = 1'b0;
`endif

endmodule

// File: tb/tb_dco_model.sv
// Directed bench for dco_model: measures every half-period against a queue of expected lengths.
module tb_dco_model;
  import dco_pkg::*;

  logic clk;
  logic reset;

  dco_model_if dco_a ();
  dco_model_if dco_b ();

  dco_model u_dut_a (
    .clk   (clk),
    .reset (reset),
    .dco   (dco_a.slave)
  );

  dco_model #(.HALF_MAX(200), .HALF_STEP(2), .HALF_MIN(2)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .dco   (dco_b.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] exp_a_q[$];
  logic [15:0] exp_b_q[$];

`ifdef DCO_THERMO_CHECK_EN
  localparam logic THERMO_ON = 1'b1;
`else
  localparam logic THERMO_ON = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  int   cyc_a = 0;
  int   cyc_b = 0;
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;
  logic rst_last = 1'b1;

  always @(negedge clk) begin
    if (rst_last) begin
      cyc_a = 0;
      cyc_b = 0;
    end else begin
      cyc_a++;
      cyc_b++;
      if (dco_a.dco_out !== prev_a) begin
        if (exp_a_q.size() > 0) check("half_a", cyc_a, exp_a_q.pop_front());
        cyc_a = 0;
      end
      if (dco_b.dco_out !== prev_b) begin
        if (exp_b_q.size() > 0) check("half_b", cyc_b, exp_b_q.pop_front());
        cyc_b = 0;
      end
    end
    prev_a   = dco_a.dco_out;
    prev_b   = dco_b.dco_out;
    rst_last = reset;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k;
    k = 0;
    while ((exp_a_q.size() > 0 || exp_b_q.size() > 0) && k < budget) begin
      step(1);
      k++;
    end
    if (exp_a_q.size() > 0 || exp_b_q.size() > 0) begin
      check({tag, "_timeout_pending"}, exp_a_q.size() + exp_b_q.size(), 0);
      exp_a_q.delete();
      exp_b_q.delete();
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [DCO_CELLS-1:0] all_ones;
    all_ones = '1;
    reset    = 1'b1;
    dco_a.en = '0;
    dco_b.en = all_ones;
    step(5);
    check("rst_out_a", dco_a.dco_out, 0);
    check("rst_err_a", dco_a.thermo_err, 0);
    check("rst_out_b", dco_b.dco_out, 0);

    // Free-running at HALF_MAX; instance b clamps to HALF_MIN after its first half.
    exp_a_q.push_back(200); exp_a_q.push_back(200); exp_a_q.push_back(200);
    exp_b_q.push_back(200);
    for (int i = 0; i < 5; i++) exp_b_q.push_back(2);
    reset = 1'b0;
    wait_drain("idle", 1000);
    check("level_after_3", dco_a.dco_out, 1);

    // N=3 applied mid-half: current half finishes at 200.
    step(50);
    dco_a.en = 132'h7;
    exp_a_q.push_back(200); exp_a_q.push_back(197); exp_a_q.push_back(197);
    step(1);
    check("err_thermo_7", dco_a.thermo_err, 0);
    wait_drain("n3", 1000);

    // All cells on: 200-132 = 68.
    step(50);
    dco_a.en = all_ones;
    exp_a_q.push_back(197); exp_a_q.push_back(68); exp_a_q.push_back(68);
    wait_drain("n132", 1000);

    // Back to N=3, then a one-cycle reset pulse while dco_out is high.
    step(30);
    dco_a.en = 132'h7;
    exp_a_q.push_back(68); exp_a_q.push_back(197);
    wait_drain("n132_to_3", 1000);
    step(99);
    check("pre_rst_level", dco_a.dco_out, 1);
    reset = 1'b1;
    step(1);
    check("rst_pulse_out_a", dco_a.dco_out, 0);
    check("rst_pulse_out_b", dco_b.dco_out, 0);
    reset = 1'b0;
    exp_a_q.push_back(200); exp_a_q.push_back(197);
    exp_b_q.push_back(200); exp_b_q.push_back(2); exp_b_q.push_back(2);
    wait_drain("after_rst", 1000);

    // Non-thermometer code: counted as N=2.
    step(50);
    dco_a.en = 132'h5;
    step(1);
    check("err_thermo_5", dco_a.thermo_err, THERMO_ON);
    exp_a_q.push_back(197); exp_a_q.push_back(198);
    wait_drain("n5", 1000);
    step(40);
    dco_a.en = 132'h3;
    step(1);
    check("err_thermo_3", dco_a.thermo_err, 0);
    exp_a_q.push_back(198); exp_a_q.push_back(198);
    wait_drain("n3b", 1000);

    // Rapid changes inside one half: only the value at the toggle counts.
    step(20);
    dco_a.en = '0;
    step(30);
    dco_a.en = 132'h7;
    step(30);
    dco_a.en = 132'hF;
    exp_a_q.push_back(198); exp_a_q.push_back(196); exp_a_q.push_back(196);
    wait_drain("rapid", 1000);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
